serial_adder_unit: RTL and testbench
====================================

// Module: serial_adder_unit
// PURPOSE
//  Parametrised bit-serial adder/subtractor: one full-adder bit slice iterated over WIDTH cycles.
//  Accepts two WIDTH-bit operands over a valid/ready handshake.
//  Returns sum, carry-out, signed overflow and zero flags over a second valid/ready handshake.
//  Sits between the operand registers and the ALU result mux.
//  Trades latency for area against the parallel ripple adder.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range 2..64
//  CNT_W   $clog2(WIDTH)+1   localparam; width of the bit counter (not overridable)
// PORTS
//  clk        in   1      single clock; all state updates on the rising edge
//  reset      in   1      asynchronous, active-high reset
//  in_valid   in   1      operands and subtract are valid
//  in_ready   out  1      unit can accept operands (high only in IDLE)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  subtract   in   1      0: A+B; 1: A-B, computed as A+~B+1
//  out_valid  out  1      result and flags valid (high only in DONE)
//  out_ready  in   1      consumer accepts the result
//  sum        out  WIDTH  result, two's complement wrap
//  carryout   out  1      carry out of MSB; for subtract, 1 = no borrow
//  overflow   out  1      signed overflow = carry into MSB XOR carry out of MSB
//  zero       out  1      sum == 0
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0. sum, carryout, overflow, zero, counter and carry reg all 0.
//   Reset takes effect immediately, also mid-RUN or in DONE; any in-flight operation is discarded.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: if in_valid at an edge (accept edge E0):
//    - latch A;
//    - latch B as b^{WIDTH{subtract}};
//    - set carry reg = subtract;
//    - set counter = 0;
//    - go to RUN.
//   RUN: each edge processes bit i = counter, LSB first. The slice adds A[0], B[0], carry.
//    - A and B shift right one bit;
//    - the slice sum bit shifts into the sum reg at its MSB end;
//    - carry reg takes the slice carry;
//    - counter increments.
//    At i = WIDTH-1, capture carry-in to the MSB (for overflow) and go to DONE.
//   DONE: out_valid=1.
//    - sum, carryout, overflow and zero are held stable until out_ready is sampled high.
//    - Then go to IDLE; out_valid drops and in_ready rises after that edge.
//  Latency: out_valid rises exactly WIDTH edges after E0.
//   Minimum initiation interval is WIDTH+2 cycles: no accept in the same cycle as result handoff.
//  in_valid, a, b and subtract are ignored outside IDLE. The operand latch is not disturbed.
//  out_ready is ignored outside DONE.
//  sum, carryout, overflow and zero are only guaranteed while out_valid=1.
//   They change only in RUN, and hold the last result in IDLE.
//  zero is derived from the final sum register (combinational NOR or registered; either is acceptable).
//  No X on any output after reset, for any input sequence.
// STRUCTURE
//  Shared header adder_defs.vh holds:
//   - state encoding localparams: S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
//   - default WIDTH.
//  State 2'd3 is illegal and returns to IDLE on the next edge.
//  Sub-module: exactly one instance of the existing structural full-adder cell (adder.v) as the bit slice.
//   No other arithmetic operators on the datapath except the counter increment.
//  Top level holds the FSM, counter, shift registers, carry/MSB-carry regs and flag logic.
// TESTING
//  Run at WIDTH=8 unless noted; check the accept-to-out_valid count on every operation.
//  1. Assert reset for 3 cycles with random inputs.
//     -> in_ready=1, out_valid=0, sum=0, all flags 0.
//  2. Add 8'h7F + 8'h01.
//     -> sum=8'h80, carryout=0, overflow=1, zero=0.
//     -> out_valid exactly 8 cycles after accept.
//  3. Add 8'hFF + 8'h01.
//     -> sum=8'h00, carryout=1, overflow=0, zero=1.
//  4. Subtract 8'h05 - 8'h05.
//     -> sum=8'h00, carryout=1, zero=1.
//     Subtract 8'h00 - 8'h01.
//     -> sum=8'hFF, carryout=0, overflow=0.
//     Subtract 8'h80 - 8'h01.
//     -> sum=8'h7F, overflow=1.
//  5. Hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with new operands.
//     -> in_ready=0 and outputs stable.
//     Then pulse out_ready.
//     -> IDLE next edge; the new operands are accepted only after in_ready=1.
//  6. Assert reset at RUN bit 3.
//     -> IDLE immediately, out_valid never asserts; the next operation 8'h12 + 8'h34 gives 8'h46.
//     At WIDTH=4, exhaustive sweep of a, b and subtract against a reference model.

Source files
------------

// File: rtl/serial_adder_unit_pkg.sv
// serial_adder_unit_pkg: shared state encoding and default operand width
package serial_adder_unit_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_DONE    = 2'd2,
        S_ILLEGAL = 2'd3
    } state_t;

endpackage

// File: rtl/serial_adder_unit_fa.sv
// serial_adder_unit_fa: structural one-bit full adder used as the serial bit slice
module serial_adder_unit_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;
    logic g;
    logic t;

    xor x_p (p, a, b);
    xor x_s (s, p, ci);
    and a_g (g, a, b);
    and a_t (t, p, ci);
    or  o_c (co, g, t);

endmodule

// File: rtl/serial_adder_unit.sv
// serial_adder_unit: bit-serial add/subtract over WIDTH cycles with valid/ready handshakes
module serial_adder_unit
    import serial_adder_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             subtract,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             fa_s;
    logic             fa_co;
    logic             last;

    serial_adder_unit_fa u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last      = cnt_q == CNT_W'(WIDTH - 1);
    assign in_ready  = state_q == S_IDLE;
    assign out_valid = state_q == S_DONE;
    assign sum       = sum_q;
    assign carryout  = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

    // next-state and datapath: latch on accept, one slice step per RUN edge, flags on the MSB step
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{subtract}};
                    carry_d = subtract;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last) begin
                    cout_d  = fa_co;
                    ovf_d   = carry_q ^ fa_co;
                    zero_d  = ~|sum_d;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = out_ready ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

endmodule

// File: tb/tb_serial_adder_unit.sv
// tb_serial_adder_unit: randomized and directed checks of the serial adder against an arithmetic model
module tb_serial_adder_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       in_valid8 = 1'b0, in_ready8, sub8 = 1'b0, out_valid8, out_ready8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       co8, ov8, z8;

    logic       in_valid4 = 1'b0, in_ready4, sub4 = 1'b0, out_valid4, out_ready4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, sum4;
    logic       co4, ov4, z4;

    int checks = 0;
    int errors = 0;

    serial_adder_unit #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .subtract(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .carryout(co8), .overflow(ov8), .zero(z8)
    );

    serial_adder_unit #(.WIDTH(4)) u4 (
        .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .subtract(sub4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .carryout(co4), .overflow(ov4), .zero(z4)
    );

    always #5 clk = ~clk;

    // arithmetic reference: unsigned result/carry and signed-range overflow
    function automatic void model(input int w, input int a, input int b, input bit sub,
                                  output int s, output bit co, output bit ov, output bit z);
        int m, h, sa, sb, r;
        m  = (1 << w) - 1;
        h  = 1 << (w - 1);
        s  = (sub ? a - b : a + b) & m;
        co = sub ? (a >= b) : (a + b > m);
        sa = a >= h ? a - (1 << w) : a;
        sb = b >= h ? b - (1 << w) : b;
        r  = sub ? sa - sb : sa + sb;
        ov = (r >= h) || (r < -h);
        z  = s == 0;
    endfunction

    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input bit sub, input bit rel,
                           output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        in_valid8 = 1'b1;
        a8 = a;
        b8 = b;
        sub8 = sub;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!out_valid8 && lat < 50);
        if (rel) begin
            @(negedge clk);
            out_ready8 = 1'b1;
            @(posedge clk);
            #1;
            out_ready8 = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid8 = 1'($urandom);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            sub8 = 1'($urandom);
            out_ready8 = 1'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if ({in_ready8, out_valid8, sum8, co8, ov8, z8} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
                errors++;
                $display("FAIL reset8 cycle %0d: rdy=%b vld=%b sum=%h c=%b o=%b z=%b want rdy=1 vld=0 sum=00 flags=000",
                         i, in_ready8, out_valid8, sum8, co8, ov8, z8);
            end
            checks++;
            if ({in_ready4, out_valid4, sum4, co4, ov4, z4} !== {1'b1, 1'b0, 4'h0, 3'b000}) begin
                errors++;
                $display("FAIL reset4 cycle %0d: rdy=%b vld=%b sum=%h flags=%b%b%b want 1 0 0 000",
                         i, in_ready4, out_valid4, sum4, co4, ov4, z4);
            end
        end
        @(negedge clk);
        in_valid8 = 1'b0;
        out_ready8 = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({in_ready8, out_valid8, sum8} !== {1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_release: rdy=%b vld=%b sum=%h want 1 0 00", in_ready8, out_valid8, sum8);
        end
    endtask

    task automatic check_op8(input string name, input int a, input int b, input bit sub, input int lat);
        int s;
        bit co, ov, z;
        model(8, a, b, sub, s, co, ov, z);
        checks++;
        if (lat != 8) begin
            errors++;
            $display("FAIL %s latency: got %0d edges want 8", name, lat);
        end
        checks++;
        if ({sum8, co8, ov8, z8} !== {s[7:0], co, ov, z}) begin
            errors++;
            $display("FAIL %s %h%s%h: sum=%h c=%b o=%b z=%b want sum=%h c=%b o=%b z=%b",
                     name, a[7:0], sub ? "-" : "+", b[7:0], sum8, co8, ov8, z8, s[7:0], co, ov, z);
        end
    endtask

    task automatic test_directed();
        int da[6] = '{'h7F, 'hFF, 'h05, 'h00, 'h80, 'h12};
        int db[6] = '{'h01, 'h01, 'h05, 'h01, 'h01, 'h34};
        bit ds[6] = '{0, 0, 1, 1, 1, 0};
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_op8(8'(da[i]), 8'(db[i]), ds[i], 1'b0, lat);
            check_op8("directed", da[i], db[i], ds[i], lat);
            @(negedge clk);
            out_ready8 = 1'b1;
            @(posedge clk);
            #1;
            out_ready8 = 1'b0;
        end
        run_op8(8'h7F, 8'h01, 1'b0, 1'b0, lat);
        checks++;
        if ({sum8, co8, ov8, z8} !== {8'h80, 3'b010}) begin
            errors++;
            $display("FAIL spec_7F+01: sum=%h c=%b o=%b z=%b want 80 0 1 0", sum8, co8, ov8, z8);
        end
        @(negedge clk);
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        out_ready8 = 1'b0;
    endtask

    task automatic test_random();
        int lat;
        logic [7:0] ra, rb;
        bit rs;
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            run_op8(ra, rb, rs, 1'b0, lat);
            check_op8("random", int'(ra), int'(rb), rs, lat);
            @(negedge clk);
            out_ready8 = 1'b1;
            @(posedge clk);
            #1;
            out_ready8 = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [7:0] held;
        run_op8(8'h3C, 8'h5A, 1'b0, 1'b1, lat);
        held = sum8;
        checks++;
        if ({in_ready8, out_valid8} !== 2'b10) begin
            errors++;
            $display("FAIL handoff: rdy=%b vld=%b want rdy=1 vld=0", in_ready8, out_valid8);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({sum8, held} !== {8'h96, 8'h96}) begin
            errors++;
            $display("FAIL idle_hold: sum=%h held=%h want 96", sum8, held);
        end
        run_op8(8'hC3, 8'h44, 1'b1, 1'b0, lat);
        check_op8("back_to_back", 'hC3, 'h44, 1'b1, lat);
        @(negedge clk);
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        out_ready8 = 1'b0;
    endtask

    task automatic test_hold();
        int lat, s;
        bit co, ov, z;
        logic [10:0] snap;
        run_op8(8'hA5, 8'h3B, 1'b1, 1'b0, lat);
        check_op8("hold_first", 'hA5, 'h3B, 1'b1, lat);
        snap = {sum8, co8, ov8, z8};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid8 = 1'b1;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            sub8 = 1'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if ({in_ready8, out_valid8, sum8, co8, ov8, z8} !== {2'b01, snap}) begin
                errors++;
                $display("FAIL hold cycle %0d: rdy=%b vld=%b out=%h want rdy=0 vld=1 out=%h",
                         i, in_ready8, out_valid8, {sum8, co8, ov8, z8}, snap);
            end
        end
        @(negedge clk);
        a8 = 8'h9E;
        b8 = 8'h27;
        sub8 = 1'b0;
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        out_ready8 = 1'b0;
        checks++;
        if ({in_ready8, out_valid8} !== 2'b10) begin
            errors++;
            $display("FAIL hold_release: rdy=%b vld=%b want rdy=1 vld=0", in_ready8, out_valid8);
        end
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        checks++;
        if (in_ready8 !== 1'b0) begin
            errors++;
            $display("FAIL hold_accept: rdy=%b want 0 after accept", in_ready8);
        end
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!out_valid8 && lat < 50);
        model(8, 'h9E, 'h27, 1'b0, s, co, ov, z);
        checks++;
        if (lat != 8 || {sum8, co8, ov8, z8} !== {s[7:0], co, ov, z}) begin
            errors++;
            $display("FAIL hold_next: lat=%0d sum=%h c=%b o=%b z=%b want lat=8 sum=%h c=%b o=%b z=%b",
                     lat, sum8, co8, ov8, z8, s[7:0], co, ov, z);
        end
        @(negedge clk);
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        out_ready8 = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int lat, seen;
        @(negedge clk);
        in_valid8 = 1'b1;
        a8 = 8'hF0;
        b8 = 8'h0F;
        sub8 = 1'b0;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({in_ready8, out_valid8, sum8, co8, ov8, z8} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
            errors++;
            $display("FAIL mid_reset: rdy=%b vld=%b sum=%h flags=%b%b%b want 1 0 00 000",
                     in_ready8, out_valid8, sum8, co8, ov8, z8);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid8) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_reset_valid: out_valid high %0d cycles want 0", seen);
        end
        run_op8(8'h12, 8'h34, 1'b0, 1'b0, lat);
        checks++;
        if (lat != 8 || sum8 !== 8'h46) begin
            errors++;
            $display("FAIL after_reset: lat=%0d sum=%h want lat=8 sum=46", lat, sum8);
        end
        @(negedge clk);
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        out_ready8 = 1'b0;
    endtask

    task automatic test_exhaustive4();
        int lat, n, s;
        bit co, ov, z;
        for (int i = 0; i < 512; i++) begin
            n = 0;
            @(negedge clk);
            while (!in_ready4 && n < 50) begin
                @(negedge clk);
                n++;
            end
            in_valid4 = 1'b1;
            a4 = 4'(i >> 5);
            b4 = 4'(i >> 1);
            sub4 = i[0];
            @(posedge clk);
            #1;
            in_valid4 = 1'b0;
            lat = 0;
            do begin
                @(posedge clk);
                lat++;
                #1;
            end while (!out_valid4 && lat < 50);
            model(4, (i >> 5) & 15, (i >> 1) & 15, i[0], s, co, ov, z);
            checks++;
            if (lat != 4 || {sum4, co4, ov4, z4} !== {s[3:0], co, ov, z}) begin
                errors++;
                $display("FAIL exh4 %h%s%h: lat=%0d sum=%h c=%b o=%b z=%b want lat=4 sum=%h c=%b o=%b z=%b",
                         4'(i >> 5), i[0] ? "-" : "+", 4'(i >> 1), lat, sum4, co4, ov4, z4, s[3:0], co, ov, z);
            end
            @(negedge clk);
            out_ready4 = 1'b1;
            @(posedge clk);
            #1;
            out_ready4 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_hold();
        test_reset_mid_run();
        test_exhaustive4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
